mult_share_arbiter: RTL

- Shares one `multiplier_csa #(N)` instance between two requesters.
- Round-robin grant, valid/ready operand handshake, and a registered product with valid/ready response handshake.
- Sits between two client datapaths and the combinational multiplier.
- Sequences operand capture, the multiply cycle and result hand-off, so clients never drive the multiplier directly.

---
 rtl/mult_share_arbiter.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/mult_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mult_share_arbiter (with multiplier_csa)
// Purpose  : Round-robin sharing of one carry-save array multiplier between
//            two valid/ready requesters, with a registered valid/ready result.
// Revision : 1.0
// ============================================================================

module multiplier_csa #(
  parameter int N = 4
) (
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic [2*N-1:0] p
);

  // Each row folds one partial product into a redundant sum/carry pair; the
  // carry shifted out of the MSB is dropped because the exact product fits.
  for (genvar i = 0; i < N; i++) begin : g_row
    logic [2*N-1:0] w_pp;
    logic [2*N-1:0] w_sum;
    logic [2*N-1:0] w_carry;

    assign w_pp = b[i] ? ({{N{1'b0}}, a} << i) : '0;

    if (i == 0) begin : g_first
      assign w_sum   = w_pp;
      assign w_carry = '0;
    end else begin : g_acc
      assign w_sum   = g_row[i-1].w_sum ^ g_row[i-1].w_carry ^ w_pp;
      assign w_carry = ((g_row[i-1].w_sum & g_row[i-1].w_carry) |
                        (g_row[i-1].w_sum & w_pp) |
                        (g_row[i-1].w_carry & w_pp)) << 1;
    end
  end

  assign p = g_row[N-1].w_sum + g_row[N-1].w_carry;

endmodule

module mult_share_arbiter #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           valid0,
  input  logic [N-1:0]   a0,
  input  logic [N-1:0]   b0,
  output logic           ready0,
  input  logic           valid1,
  input  logic [N-1:0]   a1,
  input  logic [N-1:0]   b1,
  output logic           ready1,
  output logic [2*N-1:0] result,
  output logic           result_id,
  output logic           result_valid,
  input  logic           result_ready
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [N-1:0]   r_op_a;
  logic [N-1:0]   r_op_b;
  logic           r_op_id;
  logic           r_last;
  logic [2*N-1:0] r_result;
  logic           r_result_id;
  logic           r_result_valid;
  logic [2*N-1:0] w_product;
  logic           w_grant0;
  logic           w_grant1;
  logic           w_handoff;

  // On contention the requester that was not served last wins.
  assign w_grant0 = valid0 && (!valid1 || r_last);
  assign w_grant1 = valid1 && (!valid0 || !r_last);

  multiplier_csa #(.N(N)) u_mult (
    .a (r_op_a),
    .b (r_op_b),
    .p (w_product)
  );

  always_comb begin
    w_state_nxt = r_state;
    ready0      = 1'b0;
    ready1      = 1'b0;
    w_handoff   = 1'b0;
    case (r_state)
      S_IDLE: begin
        ready0 = w_grant0;
        ready1 = w_grant1;
        if (w_grant0 || w_grant1) begin
          w_state_nxt = S_MUL;
        end
      end
      S_MUL: begin
        w_state_nxt = S_RESP;
      end
      S_RESP: begin
        if (r_result_valid && result_ready) begin
          w_handoff   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op_a         <= '0;
      r_op_b         <= '0;
      r_op_id        <= 1'b0;
      r_last         <= 1'b1;
      r_result       <= '0;
      r_result_id    <= 1'b0;
      r_result_valid <= 1'b0;
    end else begin
      if (ready0) begin
        r_op_a  <= a0;
        r_op_b  <= b0;
        r_op_id <= 1'b0;
      end else if (ready1) begin
        r_op_a  <= a1;
        r_op_b  <= b1;
        r_op_id <= 1'b1;
      end
      if (r_state == S_MUL) begin
        r_result       <= w_product;
        r_result_id    <= r_op_id;
        r_result_valid <= 1'b1;
      end
      // Fairness pointer moves only when the consumer actually takes a result.
      if (w_handoff) begin
        r_result_valid <= 1'b0;
        r_last         <= r_result_id;
      end
    end
  end

  assign result       = r_result;
  assign result_id    = r_result_id;
  assign result_valid = r_result_valid;

endmodule

`default_nettype wire
